ti_gf16_inv_pipe: RTL and testbench

- Pipelined, 4-share threshold-implementation GF(2^4) inverter for LANES parallel nibbles, with a valid/ready handshake on input and output.
- Two mandatory register stages keep the component functions glitch-separated; optional extra delay stages are added by parameter.
- Feeds the shared S-box datapath of the TI AES core. Throughput is one nibble-vector per cycle when unstalled.

---
 rtl/ti_gf16_inv_pipe.sv | 188 ++++++++++++++++++
 tb/tb_ti_gf16_inv_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ti_gf16_inv_pipe.sv
// rtl/ti_gf16_inv_pipe.sv - pipelined 4-share threshold-implementation GF(2^4) inverter
//
// Purpose: per lane, XOR(QxDO0..3) = inv(XOR(XxDI0..3)) in GF(2^4) mod x^4+x+1,
// with inv(0)=0. There are two mandatory register stages plus EXTRA_STAGES
// handshaked delay slots, and the block accepts one vector per cycle when unstalled.
//
// Ports:
//   ClkxCI        clock, rising edge
//   RstxBI        asynchronous active-low reset
//   InValidxSI    input share vector valid
//   InReadyxSO    block can accept input this cycle
//   XxDI0..3      input shares, lane i at [4i+3:4i]
//   RandxDI       12*LANES refresh randomness (only with TI_REFRESH_EN)
//   OutValidxSO   output shares valid
//   OutReadyxSI   downstream accepts output
//   QxDO0..3      output shares
//
// Build option: define TI_REFRESH_EN to re-mask input shares with RandxDI on acceptance.
module ti_gf16_inv_pipe #(
  parameter int LANES        = 1,
  parameter int EXTRA_STAGES = 0
) (
  input  logic                 ClkxCI,
  input  logic                 RstxBI,
  input  logic                 InValidxSI,
  output logic                 InReadyxSO,
  input  logic [4*LANES-1:0]   XxDI0,
  input  logic [4*LANES-1:0]   XxDI1,
  input  logic [4*LANES-1:0]   XxDI2,
  input  logic [4*LANES-1:0]   XxDI3,
`ifdef TI_REFRESH_EN
  input  logic [12*LANES-1:0]  RandxDI,
`endif
  output logic                 OutValidxSO,
  input  logic                 OutReadyxSI,
  output logic [4*LANES-1:0]   QxDO0,
  output logic [4*LANES-1:0]   QxDO1,
  output logic [4*LANES-1:0]   QxDO2,
  output logic [4*LANES-1:0]   QxDO3
);

  localparam int W  = 4 * LANES;
  localparam int NS = 2 + EXTRA_STAGES;
  localparam logic [3:0] CAP = 4'(NS);

  function automatic logic [3:0] gfInv(input logic [3:0] x);
    case (x)
      4'h0: return 4'h0;
      4'h1: return 4'h1;
      4'h2: return 4'h9;
      4'h3: return 4'hE;
      4'h4: return 4'hD;
      4'h5: return 4'hB;
      4'h6: return 4'h7;
      4'h7: return 4'h6;
      4'h8: return 4'hF;
      4'h9: return 4'h2;
      4'hA: return 4'hC;
      4'hB: return 4'h5;
      4'hC: return 4'hA;
      4'hD: return 4'h4;
      4'hE: return 4'h3;
      default: return 4'h8;
    endcase
  endfunction

  // Component functions. inv has algebraic degree 3 and no constant term, so each
  // expanded share-tuple term touches at most three share indices. Component m
  // collects the tuples that avoid index m but contain every index below m;
  // inclusion-exclusion turns that into XORs of inv over partial share sums.
  // Component m therefore never reads share m, and the four components sum to inv(x).
  function automatic logic [3:0] compQ0(input logic [3:0][3:0] s);
    return gfInv(s[1] ^ s[2] ^ s[3]);
  endfunction

  function automatic logic [3:0] compQ1(input logic [3:0][3:0] s);
    return gfInv(s[0] ^ s[2] ^ s[3]) ^ gfInv(s[2] ^ s[3]);
  endfunction

  function automatic logic [3:0] compQ2(input logic [3:0][3:0] s);
    return gfInv(s[0] ^ s[1] ^ s[3]) ^ gfInv(s[1] ^ s[3])
         ^ gfInv(s[0] ^ s[3]) ^ gfInv(s[3]);
  endfunction

  function automatic logic [3:0] compQ3(input logic [3:0][3:0] s);
    return gfInv(s[0] ^ s[1] ^ s[2]) ^ gfInv(s[1] ^ s[2])
         ^ gfInv(s[0] ^ s[2]) ^ gfInv(s[0] ^ s[1])
         ^ gfInv(s[0]) ^ gfInv(s[1]) ^ gfInv(s[2]);
  endfunction

  // Valid chain: slot 0 is the input register, slot NS-1 drives the outputs.
  logic [NS-1:0] validQ;
  logic [NS-1:0] slotReady;
  logic [NS-1:0] upValid;
  logic [NS-1:0] loadSlot;

  // A slot can take new data unless it and every slot after it are full and the
  // sink is stalled; written flat so no signal depends on itself.
  for (genvar k = 0; k < NS; k++) begin : gReady
    assign slotReady[k] = OutReadyxSI | ~(&validQ[NS-1:k]);
  end

  assign upValid  = {validQ[NS-2:0], InValidxSI};
  assign loadSlot = upValid & slotReady;

  // Stage-1 and later data registers.
  logic [3:0][W-1:0] inSh;
  logic [3:0][W-1:0] xReg;
  logic [W-1:0]      q0Reg;
  logic [W-1:0]      q2Reg;
  logic [W-1:0]      s1Q0;
  logic [W-1:0]      s1Q2;
  logic [W-1:0]      s2Q1;
  logic [W-1:0]      s2Q3;
  logic [3:0][W-1:0] qPipe [1:NS-1];
  logic [3:0]        occCnt;

  for (genvar l = 0; l < LANES; l++) begin : gLane
    logic [3:0]      r0, r1, r2;
    logic [3:0][3:0] inLane;
    logic [3:0][3:0] regLane;

`ifdef TI_REFRESH_EN
    assign r0 = RandxDI[12*l +: 4];
    assign r1 = RandxDI[12*l+4 +: 4];
    assign r2 = RandxDI[12*l+8 +: 4];
`else
    assign r0 = 4'h0;
    assign r1 = 4'h0;
    assign r2 = 4'h0;
`endif

    // The refresh mask XORs to zero across the four shares, so the secret is unchanged.
    assign inSh[0][4*l +: 4] = XxDI0[4*l +: 4] ^ r0;
    assign inSh[1][4*l +: 4] = XxDI1[4*l +: 4] ^ r1;
    assign inSh[2][4*l +: 4] = XxDI2[4*l +: 4] ^ r2;
    assign inSh[3][4*l +: 4] = XxDI3[4*l +: 4] ^ r0 ^ r1 ^ r2;

    assign inLane  = {inSh[3][4*l +: 4], inSh[2][4*l +: 4],
                      inSh[1][4*l +: 4], inSh[0][4*l +: 4]};
    assign regLane = {xReg[3][4*l +: 4], xReg[2][4*l +: 4],
                      xReg[1][4*l +: 4], xReg[0][4*l +: 4]};

    // Q0/Q2 come from the (refreshed) live shares; Q1/Q3 come only from the
    // registered copies, so the two halves are separated by a register.
    assign s1Q0[4*l +: 4] = compQ0(inLane);
    assign s1Q2[4*l +: 4] = compQ2(inLane);
    assign s2Q1[4*l +: 4] = compQ1(regLane);
    assign s2Q3[4*l +: 4] = compQ3(regLane);
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      validQ <= '0;
      xReg   <= '0;
      q0Reg  <= '0;
      q2Reg  <= '0;
      occCnt <= '0;
      for (int k = 1; k < NS; k++) qPipe[k] <= '0;
    end else begin
      // A slot whose ready is high either takes its upstream item or empties.
      validQ <= (validQ & ~slotReady) | (upValid & slotReady);
      occCnt <= occCnt + {3'b000, loadSlot[0]} - {3'b000, validQ[NS-1] & OutReadyxSI};
      // Data registers move only on a load, so idle slots never mix shares.
      if (loadSlot[0]) begin
        xReg  <= inSh;
        q0Reg <= s1Q0;
        q2Reg <= s1Q2;
      end
      if (loadSlot[1]) qPipe[1] <= {s2Q3, q2Reg, s2Q1, q0Reg};
      for (int k = 2; k < NS; k++) begin
        if (loadSlot[k]) qPipe[k] <= qPipe[k-1];
      end
    end
  end

  always @(posedge ClkxCI) begin
    if (RstxBI) assert (occCnt <= CAP);
  end

  assign InReadyxSO  = slotReady[0];
  assign OutValidxSO = validQ[NS-1];
  assign QxDO0       = qPipe[NS-1][0];
  assign QxDO1       = qPipe[NS-1][1];
  assign QxDO2       = qPipe[NS-1][2];
  assign QxDO3       = qPipe[NS-1][3];

endmodule

// File: tb/tb_ti_gf16_inv_pipe.sv
// tb/tb_ti_gf16_inv_pipe.sv - self-checking bench for ti_gf16_inv_pipe
module tb_ti_gf16_inv_pipe;

  localparam int LANES = 4;
  localparam int W     = 4 * LANES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN;
  logic [1:0]             inValid, inReady, outValid, outReady;
  logic [1:0][3:0][W-1:0] xs;
  logic [1:0][3:0][W-1:0] qs;
`ifdef TI_REFRESH_EN
  logic [1:0][12*LANES-1:0] rnd;
`endif

  // Instance 0: no extra stages (capacity 2). Instance 1: three extra stages (capacity 5).
  for (genvar g = 0; g < 2; g++) begin : gDut
    ti_gf16_inv_pipe #(.LANES(LANES), .EXTRA_STAGES(g == 0 ? 0 : 3)) dut (
      .ClkxCI      (clk),
      .RstxBI      (rstN),
      .InValidxSI  (inValid[g]),
      .InReadyxSO  (inReady[g]),
      .XxDI0       (xs[g][0]),
      .XxDI1       (xs[g][1]),
      .XxDI2       (xs[g][2]),
      .XxDI3       (xs[g][3]),
`ifdef TI_REFRESH_EN
      .RandxDI     (rnd[g]),
`endif
      .OutValidxSO (outValid[g]),
      .OutReadyxSI (outReady[g]),
      .QxDO0       (qs[g][0]),
      .QxDO1       (qs[g][1]),
      .QxDO2       (qs[g][2]),
      .QxDO3       (qs[g][3])
    );
  end

  int nCmp = 0;
  int nErr = 0;
  int stepCnt = 0;
  int occ = 0;
  int maxOcc = 0;
  logic [W-1:0] expQ[$];
  logic [W-1:0] gotQ[$];
  logic [W-1:0] gotQ0[$];
  int           gotLat[$];
  int           accStep[$];

  // Reference: textbook shift-and-add multiply mod x^4+x+1, inverse as x^14.
  function automatic logic [3:0] gfMul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [W-1:0] refInv(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   acc;
    for (int l = 0; l < LANES; l++) begin
      acc = 4'h1;
      for (int e = 0; e < 14; e++) acc = gfMul(acc, v[4*l +: 4]);
      r[4*l +: 4] = acc;
    end
    return r;
  endfunction

  task automatic clearSb();
    expQ.delete(); gotQ.delete(); gotQ0.delete(); gotLat.delete(); accStep.delete();
    occ = 0;
    maxOcc = 0;
  endtask

  // One clock cycle on DUT d: drive at the falling edge, record handshakes just after.
  task automatic step(input int d, input logic vld, input logic [W-1:0] plain,
                      input logic ordy, input logic masked);
    logic [W-1:0] r1, r2, r3;
    @(negedge clk);
    r1 = masked ? W'($urandom) : '0;
    r2 = masked ? W'($urandom) : '0;
    r3 = masked ? W'($urandom) : '0;
    xs[d][0] = plain ^ r1 ^ r2 ^ r3;
    xs[d][1] = r1;
    xs[d][2] = r2;
    xs[d][3] = r3;
    inValid[d]  = vld;
    outReady[d] = ordy;
`ifdef TI_REFRESH_EN
    rnd[d] = {16'($urandom), $urandom};
`endif
    #1;
    if (outValid[d] && outReady[d]) begin
      gotQ.push_back(qs[d][0] ^ qs[d][1] ^ qs[d][2] ^ qs[d][3]);
      gotQ0.push_back(qs[d][0]);
      if (accStep.size() > 0) gotLat.push_back(stepCnt - accStep.pop_front());
      else gotLat.push_back(-1);
      occ--;
    end
    if (inValid[d] && inReady[d]) begin
      expQ.push_back(refInv(plain));
      accStep.push_back(stepCnt);
      occ++;
    end
    if (occ > maxOcc) maxOcc = occ;
    stepCnt++;
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 60 && gotQ.size() < expQ.size(); i++) step(d, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    inValid = '0;
    outReady = '1;
    xs = '0;
`ifdef TI_REFRESH_EN
    rnd = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      nCmp++;
      if (outValid[d] !== 1'b0) begin nErr++; $display("FAIL reset_outvalid dut%0d got %b want 0", d, outValid[d]); end
      nCmp++;
      if (inReady[d] !== 1'b1) begin nErr++; $display("FAIL reset_inready dut%0d got %b want 1", d, inReady[d]); end
      nCmp++;
      if (qs[d] !== '0) begin nErr++; $display("FAIL reset_q dut%0d got %h want 0", d, qs[d]); end
    end
  endtask

  task automatic test_sweep();
    clearSb();
    for (int v = 0; v < 16; v++) step(0, 1'b1, {4{4'(v)}}, 1'b1, 1'b0);
    drain(0);
    nCmp++;
    if (gotQ.size() != 16) begin nErr++; $display("FAIL sweep_count got %0d want 16", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin nErr++; $display("FAIL sweep_val idx %0d got %h want %h", i, gotQ[i], expQ[i]); end
      nCmp++;
      if (gotLat[i] != 2) begin nErr++; $display("FAIL sweep_latency idx %0d got %0d want 2", i, gotLat[i]); end
    end
    if (gotQ.size() > 3) begin
      nCmp++;
      if (gotQ[2] !== 16'h9999) begin nErr++; $display("FAIL sweep_inv2 got %h want 9999", gotQ[2]); end
      nCmp++;
      if (gotQ[3] !== 16'hEEEE) begin nErr++; $display("FAIL sweep_inv3 got %h want eeee", gotQ[3]); end
    end
  endtask

  task automatic test_masked();
    clearSb();
    for (int i = 0; i < 5000 && expQ.size() < 1000; i++)
      step(0, $urandom_range(3) != 0, 16'h0132, $urandom_range(3) != 0, 1'b1);
    drain(0);
    nCmp++;
    if (gotQ.size() != 1000) begin nErr++; $display("FAIL masked_count got %0d want 1000", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== 16'h01E9) begin nErr++; $display("FAIL masked_const idx %0d got %h want 01e9", i, gotQ[i]); end
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin nErr++; $display("FAIL masked_model idx %0d got %h want %h", i, gotQ[i], expQ[i]); end
    end
    nCmp++;
    if (maxOcc > 2) begin nErr++; $display("FAIL masked_occupancy got %0d want <=2", maxOcc); end
  endtask

  task automatic test_backpressure(input int d);
    int cap;
    logic [3:0][W-1:0] snap;
    cap = (d == 0) ? 2 : 5;
    snap = '0;
    clearSb();
    for (int s = 0; s < cap + 3; s++) begin
      step(d, 1'b1, W'($urandom), 1'b0, 1'b1);
      if (s == cap) begin
        snap = qs[d];
        nCmp++;
        if (outValid[d] !== 1'b1) begin nErr++; $display("FAIL bp_outvalid dut%0d got %b want 1", d, outValid[d]); end
      end
    end
    nCmp++;
    if (expQ.size() != cap) begin nErr++; $display("FAIL bp_accepted dut%0d got %0d want %0d", d, expQ.size(), cap); end
    nCmp++;
    if (inReady[d] !== 1'b0) begin nErr++; $display("FAIL bp_inready dut%0d got %b want 0", d, inReady[d]); end
    nCmp++;
    if (qs[d] !== snap) begin nErr++; $display("FAIL bp_stable dut%0d got %h want %h", d, qs[d], snap); end
    nCmp++;
    if (maxOcc != cap) begin nErr++; $display("FAIL bp_occupancy dut%0d got %0d want %0d", d, maxOcc, cap); end
    // Full pipeline, both sides ready: one in and one out in the same cycle.
    step(d, 1'b1, W'($urandom), 1'b1, 1'b1);
    nCmp++;
    if (gotQ.size() != 1 || expQ.size() != cap + 1) begin
      nErr++;
      $display("FAIL bp_simul dut%0d got out=%0d in=%0d want out=1 in=%0d", d, gotQ.size(), expQ.size(), cap + 1);
    end
    drain(d);
    nCmp++;
    if (gotQ.size() != cap + 1) begin nErr++; $display("FAIL bp_drain_count dut%0d got %0d want %0d", d, gotQ.size(), cap + 1); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin nErr++; $display("FAIL bp_order dut%0d idx %0d got %h want %h", d, i, gotQ[i], expQ[i]); end
    end
  endtask

  task automatic test_reset_midflight(input int d);
    int cap;
    cap = (d == 0) ? 2 : 5;
    clearSb();
    for (int s = 0; s < cap + 3; s++) step(d, 1'b1, W'($urandom), 1'b0, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    nCmp++;
    if (outValid[d] !== 1'b0) begin nErr++; $display("FAIL mid_reset_outvalid dut%0d got %b want 0", d, outValid[d]); end
    nCmp++;
    if (qs[d] !== '0) begin nErr++; $display("FAIL mid_reset_q dut%0d got %h want 0", d, qs[d]); end
    @(posedge clk);
    #2;
    rstN = 1'b1;
    clearSb();
    #1;
    nCmp++;
    if (inReady[d] !== 1'b1) begin nErr++; $display("FAIL mid_reset_inready dut%0d got %b want 1", d, inReady[d]); end
    for (int s = 0; s < 12; s++) step(d, 1'b0, '0, 1'b1, 1'b0);
    nCmp++;
    if (gotQ.size() != 0) begin nErr++; $display("FAIL mid_reset_stale dut%0d got %0d outputs want 0", d, gotQ.size()); end
  endtask

  task automatic test_refresh();
    int nVary;
    clearSb();
    for (int t = 0; t < 256; t++) step(0, 1'b1, 16'h3333, 1'b1, 1'b0);
    drain(0);
    nCmp++;
    if (gotQ.size() != 256) begin nErr++; $display("FAIL refresh_count got %0d want 256", gotQ.size()); end
    nVary = 0;
    for (int i = 0; i < gotQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== 16'hEEEE) begin nErr++; $display("FAIL refresh_val idx %0d got %h want eeee", i, gotQ[i]); end
      if (i > 0 && gotQ0[i] !== gotQ0[0]) nVary++;
    end
`ifdef TI_REFRESH_EN
    nCmp++;
    if (nVary == 0) begin nErr++; $display("FAIL refresh_vary got %0d differing Q0 shares want >0", nVary); end
`endif
  endtask

  task automatic test_extra_stages();
    clearSb();
    for (int s = 0; s < 6; s++) step(1, 1'b1, W'($urandom), 1'b1, 1'b1);
    drain(1);
    nCmp++;
    if (gotQ.size() != 6) begin nErr++; $display("FAIL extra_count got %0d want 6", gotQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin nErr++; $display("FAIL extra_val idx %0d got %h want %h", i, gotQ[i], expQ[i]); end
      nCmp++;
      if (gotLat[i] != 5) begin nErr++; $display("FAIL extra_latency idx %0d got %0d want 5", i, gotLat[i]); end
    end
    clearSb();
    for (int s = 0; s < 80; s++) step(1, (s % 2) == 0, W'($urandom), (s % 2) == 1, 1'b1);
    for (int s = 0; s < 60; s++) step(1, (s % 3) != 0, W'($urandom), (s % 4) == 0, 1'b1);
    drain(1);
    nCmp++;
    if (gotQ.size() != expQ.size()) begin nErr++; $display("FAIL extra_alt_count got %0d want %0d", gotQ.size(), expQ.size()); end
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      nCmp++;
      if (gotQ[i] !== expQ[i]) begin nErr++; $display("FAIL extra_alt_order idx %0d got %h want %h", i, gotQ[i], expQ[i]); end
    end
    nCmp++;
    if (maxOcc > 5) begin nErr++; $display("FAIL extra_occupancy got %0d want <=5", maxOcc); end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sweep();
    test_masked();
    test_backpressure(0);
    test_backpressure(1);
    test_reset_midflight(0);
    test_reset_midflight(1);
    test_refresh();
    test_extra_stages();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
